// File: rtl/float_convert_unit.sv
// rtl/float_convert_unit.sv - two-stage pipelined integer<->float conversion unit (ITOF / FTOI)
//
// Float format: sign | exponent (EXP_W, bias 2^(EXP_W-1)-1) | trailing mantissa (MAN_W),
// implicit leading 1. Integers are INT_W-bit two's complement; INT_W = 1+EXP_W+MAN_W.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     op offered
//   in_ready     unit accepts the op this cycle (combinational, independent of in_valid)
//   in_mode      0 = ITOF, 1 = FTOI
//   in_data      source operand
//   in_tag       opaque tag, passed through
//   out_valid    result available
//   out_ready    consumer takes the result
//   out_data     converted value
//   out_tag      tag of the result
//   out_inexact  nonzero bits were discarded
//   out_ovf      FTOI saturated
//
// Optional feature macro: FLOAT_CONVERT_ROUND_NEAREST_EN (round-to-nearest-even in both
// directions instead of truncation).

module float_convert_unit #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7,
   parameter int INT_W = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [INT_W-1:0] in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_inexact,
   output logic             out_ovf
);

   localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int P_W   = $clog2(INT_W);
   localparam int REM_W = INT_W - 1 - MAN_W;

   localparam logic [EXP_W-1:0] BIAS_E    = EXP_W'(BIAS);
   localparam logic [EXP_W-1:0] BIAS_M1_E = EXP_W'(BIAS - 1);
   localparam logic [EXP_W:0]   K_BIG_E   = (EXP_W + 1)'(BIAS + INT_W);

   // ---------------------------------------------------------------- handshake
   logic s1_valid;
   logic s2_accept;

   assign s2_accept = !out_valid || out_ready;
   assign in_ready  = !s1_valid || s2_accept;

   // ---------------------------------------------------------------- stage 1
   logic             in_sign;
   logic [INT_W-1:0] in_mag;
   logic [P_W-1:0]   in_p;

   assign in_sign = in_data[INT_W-1];
   // Unsigned INT_W-bit negate, so the most negative input yields 2^(INT_W-1).
   assign in_mag  = in_sign ? (~in_data + INT_W'(1)) : in_data;

   always_comb begin
      in_p = '0;
      for (int i = 0; i < INT_W; i++) begin
         if (in_mag[i]) in_p = P_W'(i);
      end
   end

   logic             s1_mode;
   logic             s1_sign;
   logic [INT_W-1:0] s1_mag;
   logic [P_W-1:0]   s1_p;
   logic [EXP_W-1:0] s1_exp;
   logic [MAN_W-1:0] s1_man;
   logic [TAG_W-1:0] s1_tag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
         s1_p     <= '0;
         s1_exp   <= '0;
         s1_man   <= '0;
         s1_tag   <= '0;
      end else begin
         // When in_ready is high stage 1 is either empty or draining into stage 2.
         if (in_ready) s1_valid <= in_valid;
         if (in_valid && in_ready) begin
            s1_mode <= in_mode;
            s1_sign <= in_sign;
            s1_mag  <= in_mag;
            s1_p    <= in_p;
            s1_exp  <= in_data[INT_W-2:MAN_W];
            s1_man  <= in_data[MAN_W-1:0];
            s1_tag  <= in_tag;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2: ITOF
   logic [P_W-1:0]         itof_lz;
   logic [INT_W-2:0]       itof_norm;
   logic [MAN_W-1:0]       itof_man;
   logic [REM_W-1:0]       itof_rem;
   logic [EXP_W-1:0]       itof_exp;
   logic [INT_W-2:0]       itof_packed;
   logic                   itof_zero;
   logic [INT_W-1:0]       itof_data;
   logic                   itof_inexact;

   // Shift the leading 1 up to bit INT_W-1 and drop it; what remains is mantissa then
   // discarded bits, already left-aligned and zero-filled for small magnitudes.
   assign itof_lz   = P_W'(INT_W - 1) - s1_p;
   assign itof_norm = (INT_W - 1)'(s1_mag << itof_lz);
   assign itof_man  = itof_norm[INT_W-2 -: MAN_W];
   assign itof_rem  = itof_norm[REM_W-1:0];
   assign itof_exp  = BIAS_E + EXP_W'(s1_p);

`ifdef FLOAT_CONVERT_ROUND_NEAREST_EN
   logic itof_up;
   assign itof_up = itof_rem[REM_W-1] && ((|itof_rem[REM_W-2:0]) || itof_man[0]);
   // A carry out of the mantissa ripples into the exponent and leaves the mantissa clear.
   assign itof_packed = {itof_exp, itof_man} + (INT_W - 1)'(itof_up);
`else
   assign itof_packed = {itof_exp, itof_man};
`endif

   assign itof_zero    = (s1_mag == '0);
   assign itof_data    = itof_zero ? '0 : {s1_sign, itof_packed};
   assign itof_inexact = !itof_zero && (|itof_rem);

   // ---------------------------------------------------------------- stage 2: FTOI
   logic                   f_zero;
   logic                   f_inf;
   logic                   f_neg_k;
   logic                   f_big_k;
   logic [P_W-1:0]         f_shamt;
   logic [INT_W+MAN_W-1:0] f_full;
   logic [INT_W-1:0]       f_int;
   logic [MAN_W-1:0]       f_frac;
   logic [INT_W:0]         f_mag;
   logic [INT_W-1:0]       f_small;
   logic [INT_W-1:0]       f_sat;
   logic                   f_too_big;
   logic                   f_min_neg;
   logic [INT_W-1:0]       f_data;
   logic                   f_inexact;
   logic                   f_ovf;

   assign f_zero  = (s1_exp == '0);
   assign f_inf   = (&s1_exp);
   assign f_neg_k = (s1_exp < BIAS_E);
   assign f_big_k = ({1'b0, s1_exp} >= K_BIG_E);
   // Only meaningful for 0 <= k <= INT_W-1, which is all that reaches the shift result.
   assign f_shamt = P_W'(s1_exp - BIAS_E);
   // Fixed point with MAN_W fraction bits: {1,m} * 2^k.
   assign f_full  = {{(INT_W-1){1'b0}}, 1'b1, s1_man} << f_shamt;
   assign f_int   = f_full[INT_W+MAN_W-1:MAN_W];
   assign f_frac  = f_full[MAN_W-1:0];

`ifdef FLOAT_CONVERT_ROUND_NEAREST_EN
   logic f_up;
   assign f_up    = f_frac[MAN_W-1] && ((|f_frac[MAN_W-2:0]) || f_int[0]);
   assign f_mag   = {1'b0, f_int} + (INT_W + 1)'(f_up);
   // 0.5 < |x| < 1 rounds to 1; exactly 0.5 ties to even (0).
   assign f_small = INT_W'((s1_exp == BIAS_M1_E) && (|s1_man));
`else
   assign f_mag   = {1'b0, f_int};
   assign f_small = '0;
`endif

   assign f_sat     = s1_sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
   assign f_too_big = f_mag[INT_W] || f_mag[INT_W-1];
   // -2^(INT_W-1) is representable even though its magnitude is not.
   assign f_min_neg = s1_sign && (f_mag == {2'b01, {(INT_W-1){1'b0}}});

   always_comb begin
      f_data    = '0;
      f_inexact = 1'b0;
      f_ovf     = 1'b0;
      if (f_zero) begin
         f_inexact = |s1_man;
      end else if (f_inf) begin
         f_data = f_sat;
         f_ovf  = 1'b1;
      end else if (f_neg_k) begin
         f_inexact = 1'b1;
         f_data    = s1_sign ? (~f_small + INT_W'(1)) : f_small;
      end else if (f_big_k) begin
         f_data = f_sat;
         f_ovf  = 1'b1;
      end else begin
         f_inexact = |f_frac;
         if (f_too_big && !f_min_neg) begin
            f_data = f_sat;
            f_ovf  = 1'b1;
         end else begin
            f_data = s1_sign ? (~f_mag[INT_W-1:0] + INT_W'(1)) : f_mag[INT_W-1:0];
         end
      end
   end

   // ---------------------------------------------------------------- stage 2 register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_tag     <= '0;
         out_inexact <= 1'b0;
         out_ovf     <= 1'b0;
      end else if (s2_accept) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data    <= s1_mode ? f_data : itof_data;
            out_tag     <= s1_tag;
            out_inexact <= s1_mode ? f_inexact : itof_inexact;
            out_ovf     <= s1_mode ? f_ovf : 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_float_convert_unit.sv
// tb/tb_float_convert_unit.sv - scoreboard bench for float_convert_unit at default parameters

module tb_float_convert_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [15:0] in_data;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_tag;
   logic        out_inexact;
   logic        out_ovf;

   float_convert_unit dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mode     (in_mode),
      .in_data     (in_data),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .out_inexact (out_inexact),
      .out_ovf     (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  tag;
      logic [15:0] data;
      logic        inx;
      logic        ovf;
   } exp_t;

   typedef struct packed {
      logic        mode;
      logic [15:0] d;
      logic [15:0] q;
      logic        inx;
      logic        ovf;
   } dir_t;

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t sb[$];
   dir_t dirs[$];

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] tag, input logic [15:0] data,
                               input logic inx, input logic ovf);
      exp_t r;
      r.tag = tag; r.data = data; r.inx = inx; r.ovf = ovf;
      return r;
   endfunction

   // Reference model built from plain integer arithmetic.
   function automatic exp_t model(input logic mode, input logic [15:0] d, input logic [3:0] tag);
      exp_t r;
      int mag, p, man, rem, val, e, m, k, full, frac;
      logic s;
      r = mk(tag, 16'h0000, 1'b0, 1'b0);
      s = d[15];
      if (!mode) begin
         if (d != 16'h0000) begin
            mag = s ? (65536 - int'(d)) : int'(d);
            p = 0;
            for (int i = 0; i < 17; i++) if (((mag >> i) & 1) == 1) p = i;
            if (p >= 7) begin
               man = (mag >> (p - 7)) & 127;
               rem = mag & ((1 << (p - 7)) - 1);
            end else begin
               man = (mag << (7 - p)) & 127;
               rem = 0;
            end
            r.inx = (rem != 0);
            val = ((127 + p) << 7) | man;
`ifdef FLOAT_CONVERT_ROUND_NEAREST_EN
            if (p > 7) begin
               if (rem > (1 << (p - 8)) || (rem == (1 << (p - 8)) && (man % 2) == 1)) val++;
            end
`endif
            r.data = {s, 15'(val)};
         end
      end else begin
         e = int'(d[14:7]);
         m = int'(d[6:0]);
         if (e == 0) begin
            r.inx = (m != 0);
         end else if (e == 255) begin
            r.ovf = 1'b1; r.data = s ? 16'h8000 : 16'h7FFF;
         end else begin
            k = e - 127;
            if (k < 0) begin
               r.inx = 1'b1;
               val = 0;
`ifdef FLOAT_CONVERT_ROUND_NEAREST_EN
               if (k == -1 && m != 0) val = 1;
`endif
               r.data = s ? 16'(-val) : 16'(val);
            end else if (k >= 16) begin
               r.ovf = 1'b1; r.data = s ? 16'h8000 : 16'h7FFF;
            end else begin
               full = (128 + m) << k;
               val  = full >> 7;
               frac = full & 127;
               r.inx = (frac != 0);
`ifdef FLOAT_CONVERT_ROUND_NEAREST_EN
               if (frac > 64 || (frac == 64 && (val % 2) == 1)) val++;
`endif
               if (val > 32767 && !(s && val == 32768)) begin
                  r.ovf = 1'b1; r.data = s ? 16'h8000 : 16'h7FFF;
               end else begin
                  r.data = s ? 16'(-val) : 16'(val);
               end
            end
         end
      end
      return r;
   endfunction

   // Drive one op from posedge+1, push its expectation on the accept, return cycles taken.
   task automatic send(input logic mode, input logic [15:0] d, input logic [3:0] tag,
                       input exp_t e, output int waited);
      bit acc;
      acc = 1'b0;
      waited = 0;
      in_valid = 1'b1; in_mode = mode; in_data = d; in_tag = tag;
      while (!acc && waited < 50) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         waited++;
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while (sb.size() != 0 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   // Output side of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("out_tag", 32'(out_tag), 32'(e.tag));
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_inexact", 32'(out_inexact), 32'(e.inx));
            check("out_ovf", 32'(out_ovf), 32'(e.ovf));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d results outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int   w;
      int   total;
      logic md;
      logic [15:0] d;

      reset = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;

      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_inexact", 32'(out_inexact), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      #10 reset = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed conversions, each with a latency check.
      dirs.push_back('{1'b0, 16'h0001, 16'h3F80, 1'b0, 1'b0});
      dirs.push_back('{1'b0, 16'hFFFF, 16'hBF80, 1'b0, 1'b0});
      dirs.push_back('{1'b0, 16'h8000, 16'hC700, 1'b0, 1'b0});
      dirs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
`ifdef FLOAT_CONVERT_ROUND_NEAREST_EN
      dirs.push_back('{1'b0, 16'h0103, 16'h4382, 1'b1, 1'b0});
      dirs.push_back('{1'b0, 16'h7FFF, 16'h4700, 1'b1, 1'b0});
      dirs.push_back('{1'b1, 16'h3FC0, 16'h0002, 1'b1, 1'b0});
      dirs.push_back('{1'b1, 16'h3F40, 16'h0001, 1'b1, 1'b0});
`else
      dirs.push_back('{1'b0, 16'h0103, 16'h4381, 1'b1, 1'b0});
      dirs.push_back('{1'b0, 16'h7FFF, 16'h46FF, 1'b1, 1'b0});
      dirs.push_back('{1'b1, 16'h3FC0, 16'h0001, 1'b1, 1'b0});
      dirs.push_back('{1'b1, 16'h3F40, 16'h0000, 1'b1, 1'b0});
`endif
      dirs.push_back('{1'b1, 16'h4381, 16'h0102, 1'b0, 1'b0});
      dirs.push_back('{1'b1, 16'hC700, 16'h8000, 1'b0, 1'b0});
      dirs.push_back('{1'b1, 16'h4700, 16'h7FFF, 1'b0, 1'b1});
      dirs.push_back('{1'b1, 16'h3F00, 16'h0000, 1'b1, 1'b0});
      dirs.push_back('{1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0});
      dirs.push_back('{1'b1, 16'hFF80, 16'h8000, 1'b0, 1'b1});
      dirs.push_back('{1'b1, 16'hC701, 16'h8000, 1'b0, 1'b1});
      dirs.push_back('{1'b1, 16'hBF80, 16'hFFFF, 1'b0, 1'b0});

      foreach (dirs[i]) begin
         send(dirs[i].mode, dirs[i].d, 4'(i),
              mk(4'(i), dirs[i].q, dirs[i].inx, dirs[i].ovf), w);
         check("lat_accept_cycles", 32'(w), 32'd1);
         @(negedge clk);
         check("lat_cycle1_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
         check("lat_cycle2_valid", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
      end
      drain("directed_drain");

      // Backpressure: two ops fill the pipe, the third is refused until out_ready rises.
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h0001; in_tag = 4'd1;
      @(negedge clk);
      check("bp_ready_t1", 32'(in_ready), 32'd1);
      sb.push_back(mk(4'd1, 16'h3F80, 1'b0, 1'b0));
      @(posedge clk); #1;
      in_data = 16'hFFFF; in_tag = 4'd2;
      @(negedge clk);
      check("bp_ready_t2", 32'(in_ready), 32'd1);
      sb.push_back(mk(4'd2, 16'hBF80, 1'b0, 1'b0));
      @(posedge clk); #1;
      in_data = 16'h8000; in_tag = 4'd3;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_ready_t3", 32'(in_ready), 32'd0);
         check("bp_stall_valid", 32'(out_valid), 32'd1);
         check("bp_stall_data", 32'(out_data), 32'h3F80);
         check("bp_stall_tag", 32'(out_tag), 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      check("bp_out1_tag", 32'(out_tag), 32'd1);
      if (in_ready) sb.push_back(mk(4'd3, 16'hC700, 1'b0, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_out2_valid", 32'(out_valid), 32'd1);
      check("bp_out2_tag", 32'(out_tag), 32'd2);
      @(negedge clk);
      check("bp_out3_valid", 32'(out_valid), 32'd1);
      check("bp_out3_tag", 32'(out_tag), 32'd3);
      @(negedge clk);
      check("bp_empty_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      drain("bp_drain");

      // Reset with two ops in flight.
      out_ready = 1'b0;
      send(1'b0, 16'h0005, 4'd5, model(1'b0, 16'h0005, 4'd5), w);
      send(1'b1, 16'h4381, 4'd6, model(1'b1, 16'h4381, 4'd6), w);
      #2;
      reset = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_out_tag", 32'(out_tag), 32'd0);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("held_rst_out_valid", 32'(out_valid), 32'd0);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      send(1'b0, 16'h0002, 4'd7, mk(4'd7, 16'h4000, 1'b0, 1'b0), w);
      drain("post_rst_drain");

      // Streaming: back-to-back random ops, one accept per cycle.
      total = 0;
      for (int i = 0; i < 100; i++) begin
         md = 1'($urandom_range(0, 1));
         d  = 16'($urandom);
         if (md && $urandom_range(0, 1) == 1) d[14:7] = 8'($urandom_range(115, 145));
         send(md, d, 4'(i), model(md, d, 4'(i)), w);
         total += w;
      end
      check("stream_cycles", 32'(total), 32'd100);
      drain("stream_drain");

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/float_convert_unit.md
Name: float_convert_unit

Overview:
- Pipelined, parametrised integer<->float conversion unit for the execute stage. It implements the ITOF and FTOI opcodes.
- Float format is sign | exponent | trailing mantissa with an implicit leading 1. At defaults this is the 16-bit sign[15], exp[14:7], trail[6:0] format, bias 127.
- Two-stage valid/ready pipeline with full backpressure and a tag carried through, so the issuing stage can retire results out of band.
- Bubbles are collapsed: an empty stage accepts a new op even while downstream is stalled.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 7, trailing mantissa width.
- INT_W, 16, integer width. Must equal 1+EXP_W+MAN_W, because float and int share the data bus. Must also satisfy INT_W-1 <= BIAS.
- TAG_W, 4, width of the opaque tag (destination register index).

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  op offered.
- in_ready  out  1  unit accepts the op this cycle.
- in_mode  in  1  0 = ITOF, 1 = FTOI.
- in_data  in  INT_W  source operand.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  INT_W  converted value.
- out_tag  out  TAG_W  tag of the result.
- out_inexact  out  1  nonzero bits discarded by the conversion.
- out_ovf  out  1  FTOI saturated.

Behaviour:
- Reset (reset low, takes effect immediately, no clock needed):
  - both stage valids cleared; out_valid=0.
  - out_data, out_tag, out_inexact, out_ovf all 0.
  - in-flight ops are discarded.
  - in_ready=1 from the first clk edge after release.
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready at posedge clk.
  - Output transfer occurs on out_valid & out_ready.
  - s2_accept = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_accept. This is combinational; it never depends on in_valid.
- Latency and throughput:
  - 2 cycles, accept edge to out_valid high, when unstalled.
  - Throughput 1 op per cycle. Capacity 2 ops.
- Results stay stable while out_valid & !out_ready: out_data, out_tag and flags must not change.
- Stage 1:
  - ITOF: sign = in_data[INT_W-1]; mag = sign ? -in_data : in_data, taken as unsigned INT_W bits (so the most negative value works); p = index of the leading 1 of mag.
  - FTOI: unpack sign, e, m.
- Stage 2: normalise, round, pack; register the result and flags.
- ITOF rules:
  - in_data = 0 -> out_data 0, flags 0.
  - Otherwise exp = BIAS+p; mantissa = the MAN_W bits below the leading 1, left-aligned and zero-filled when p < MAN_W; truncated.
  - out_inexact = any discarded bit nonzero. out_ovf always 0.
- FTOI rules:
  - e = 0 -> 0 (flush to zero); inexact = (m != 0).
  - e = all ones -> saturate to max positive (sign=0) or min negative (sign=1); ovf=1.
  - k = e-BIAS < 0 -> 0; inexact=1.
  - Otherwise the value is {1,m} shifted by k-MAN_W, truncated toward zero; inexact = any fraction bit dropped. The sign is then applied by two's complement.
  - |value| > 2^(INT_W-1)-1 -> saturate, ovf=1. Exception: exactly -2^(INT_W-1) is valid, with no ovf.
- Simultaneous events:
  - Output handshake and new input on the same edge: both proceed.
  - Reset low while clk toggles: held in the reset state.

Optional Feature:
- Macro: FLOAT_CONVERT_ROUND_NEAREST_EN.
- When defined, both directions use round-to-nearest-even instead of truncation:
  - ITOF: a rounding carry out of the mantissa increments the exponent and clears the mantissa.
  - FTOI: a rounded magnitude exceeding the range saturates with ovf=1.
  - out_inexact keeps its meaning: the pre-rounding discarded bits were nonzero.
- When undefined: truncation as specified above, and no rounding logic is synthesised.

Test Plan:
- ITOF 16'h0001 -> 16'h3F80; ITOF 16'hFFFF -> 16'hBF80; ITOF 16'h8000 -> 16'hC700. All with flags 0 and out_valid exactly 2 cycles after accept.
- ITOF 16'h0103 -> 16'h4381, inexact=1. With FLOAT_CONVERT_ROUND_NEAREST_EN -> 16'h4382 (tie rounded to even).
- FTOI 16'h4381 -> 16'h0102, flags 0. FTOI 16'hC700 -> 16'h8000, ovf=0. FTOI 16'h4700 -> 16'h7FFF, ovf=1. FTOI 16'h3F00 -> 16'h0000, inexact=1.
- Backpressure:
  - Hold out_ready=0 and offer ops with tags 1, 2, 3 back to back.
  - Required: tags 1 and 2 accepted, in_ready=0 on the third; out_data and out_tag=1 stable for the whole stall.
  - Raise out_ready: results emerge in order 1, 2, 3, one per cycle.
- Reset mid-operation: two ops in flight, drop reset between clk edges -> out_valid=0 and in_ready=1 immediately. After release, no stale result appears, and a new op ITOF 16'h0002 -> 16'h4000.
- Streaming: 100 random back-to-back ops with out_ready=1 -> one result per cycle, all matching the reference model.
